// File: rtl/bp_be_stride_prefetcher.sv
// PC-indexed stride prefetcher: a direct-mapped reference prediction table feeding a burst generator.
// Define BP_BE_STRIDE_PF_RUNAHEAD_EN to issue one far-ahead address on STEADY->STEADY hits.
module bp_be_stride_prefetcher #(
    parameter int vaddr_width_p  = 39,
    parameter int rpt_sets_p     = 32,
    parameter int stride_width_p = 12,
    parameter int pc_tag_width_p = 10,
    parameter int pf_degree_p    = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    input  logic [vaddr_width_p-1:0] eff_addr_i,
    output logic                     pf_v_o,
    output logic [vaddr_width_p-1:0] pf_addr_o,
    input  logic                     pf_ready_and_i,
    output logic                     busy_o
);
    localparam int lg_sets_lp = (rpt_sets_p > 1) ? $clog2(rpt_sets_p) : 1;
    localparam int tag_lsb_lp = 2 + lg_sets_lp;
    localparam int ext_lp     = vaddr_width_p - stride_width_p;
    localparam logic [vaddr_width_p-1:0] degree_lp = vaddr_width_p'(pf_degree_p);

    typedef enum logic [1:0] {e_init, e_transient, e_steady, e_nopred} rpt_state_e;
    typedef enum logic {e_idle, e_issue} gen_state_e;

    logic [rpt_sets_p-1:0]     valid_r;
    logic [pc_tag_width_p-1:0] tag_r    [rpt_sets_p];
    logic [vaddr_width_p-1:0]  prev_r   [rpt_sets_p];
    logic [stride_width_p-1:0] stride_r [rpt_sets_p];
    rpt_state_e                state_r  [rpt_sets_p];

    logic [lg_sets_lp-1:0]     idx;
    logic [pc_tag_width_p-1:0] tag;
    logic                      unused_pc;

    assign idx       = pc_i[2 +: lg_sets_lp];
    assign tag       = pc_i[tag_lsb_lp +: pc_tag_width_p];
    assign unused_pc = ^{pc_i[1:0], pc_i[vaddr_width_p-1:tag_lsb_lp+pc_tag_width_p]};

    logic                      hit, repr, match;
    logic [vaddr_width_p-1:0]  delta, stride_ext;
    logic [ext_lp:0]           delta_hi;
    logic [stride_width_p-1:0] cur_stride, next_stride;
    rpt_state_e                cur_state, next_state;

    assign cur_stride = stride_r[idx];
    assign cur_state  = state_r[idx];
    assign hit        = valid_r[idx] && (tag_r[idx] == tag);
    assign delta      = eff_addr_i - prev_r[idx];
    // delta fits the stride field only if everything above its sign bit is a sign copy
    assign delta_hi   = delta[vaddr_width_p-1:stride_width_p-1];
    assign repr       = (&delta_hi) || (~|delta_hi);
    assign stride_ext = {{ext_lp{cur_stride[stride_width_p-1]}}, cur_stride};
    assign match      = repr && (delta == stride_ext);

    always_comb begin
        next_state  = e_init;
        next_stride = '0;
        if (hit) begin
            case (cur_state)
                e_init:      next_state = match ? e_steady : e_transient;
                e_transient: next_state = match ? e_steady : e_nopred;
                e_steady:    next_state = match ? e_steady : e_init;
                default:     next_state = match ? e_transient : e_nopred;
            endcase
            // a broken steady stream keeps its stride so it can re-lock quickly
            if (match || cur_state == e_steady)
                next_stride = cur_stride;
            else if (repr)
                next_stride = delta[stride_width_p-1:0];
        end
    end

    logic                     trigger;
    logic [vaddr_width_p-1:0] first_addr;
    logic [3:0]               load_count;

    assign trigger = v_i && !reset_i && hit && (next_state == e_steady) && (next_stride != '0);

`ifdef BP_BE_STRIDE_PF_RUNAHEAD_EN
    always_comb begin
        first_addr = eff_addr_i + stride_ext;
        load_count = 4'(pf_degree_p);
        // already streaming: the nearer lines were covered by earlier bursts
        if (cur_state == e_steady) begin
            first_addr = eff_addr_i + degree_lp * stride_ext;
            load_count = 4'd1;
        end
    end
`else
    logic [vaddr_width_p-1:0] unused_degree;
    assign unused_degree = degree_lp;
    assign first_addr    = eff_addr_i + stride_ext;
    assign load_count    = 4'(pf_degree_p);
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            valid_r <= '0;
        else if (v_i)
            valid_r[idx] <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (v_i && !reset_i) begin
            tag_r[idx]    <= tag;
            prev_r[idx]   <= eff_addr_i;
            stride_r[idx] <= next_stride;
            state_r[idx]  <= next_state;
        end
    end

    gen_state_e               gen_r, gen_n;
    logic [vaddr_width_p-1:0] pf_addr_r, step_r;
    logic [3:0]               remain_r;
    logic                     handshake, last;

    assign handshake = (gen_r == e_issue) && pf_ready_and_i;
    assign last      = handshake && (remain_r == 4'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            gen_r <= e_idle;
        else
            gen_r <= gen_n;
    end

    always_comb begin
        gen_n  = gen_r;
        pf_v_o = 1'b0;
        busy_o = 1'b0;
        case (gen_r)
            e_idle: begin
                if (trigger)
                    gen_n = e_issue;
            end
            default: begin
                pf_v_o = 1'b1;
                busy_o = 1'b1;
                // a new trigger wins over finishing, giving preemption and gapless chaining
                if (trigger)
                    gen_n = e_issue;
                else if (last)
                    gen_n = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pf_addr_r <= '0;
            step_r    <= '0;
            remain_r  <= '0;
        end else if (trigger) begin
            pf_addr_r <= first_addr;
            step_r    <= stride_ext;
            remain_r  <= load_count;
        end else if (handshake) begin
            pf_addr_r <= pf_addr_r + step_r;
            remain_r  <= remain_r - 4'd1;
        end
    end

    assign pf_addr_o = pf_addr_r;

endmodule

// File: tb/tb_bp_be_stride_prefetcher.sv
// Scoreboard bench for bp_be_stride_prefetcher: per-scenario stimulus tables, expected prefetch queue.
module tb_bp_be_stride_prefetcher;
    localparam int W = 39;
    typedef logic [W-1:0] addr_t;
    typedef struct {
        logic  v;
        addr_t pc;
        addr_t addr;
        logic  rdy;
        logic  rst;
    } stim_t;

    localparam addr_t PC_A = 39'h1000;
    localparam addr_t PC_B = 39'h1004;
    localparam addr_t PC_C = 39'h2000;

    logic  clk = 1'b0;
    logic  reset_i, v_i, pf_v_o, pf_ready_and_i, busy_o;
    addr_t pc_i, eff_addr_i, pf_addr_o;

    int    checks   = 0;
    int    failures = 0;
    stim_t stim[$];
    addr_t exp_q[$];

    always #5 clk = ~clk;

    bp_be_stride_prefetcher dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .pc_i(pc_i), .eff_addr_i(eff_addr_i),
        .pf_v_o(pf_v_o), .pf_addr_o(pf_addr_o), .pf_ready_and_i(pf_ready_and_i), .busy_o(busy_o)
    );

    function automatic void add(logic v, addr_t pc, addr_t addr, logic rdy, logic rst);
        stim_t s;
        s.v = v; s.pc = pc; s.addr = addr; s.rdy = rdy; s.rst = rst;
        stim.push_back(s);
    endfunction

    function automatic void idle(int n, logic rdy);
        for (int k = 0; k < n; k++) add(1'b0, '0, '0, rdy, 1'b0);
    endfunction

    function automatic void expect_burst(addr_t base, addr_t step, int n);
        for (int k = 1; k <= n; k++) exp_q.push_back(base + addr_t'(k) * step);
    endfunction

    task automatic drive(int i);
        @(negedge clk);
        reset_i        = stim[i].rst;
        v_i            = stim[i].v;
        pc_i           = stim[i].pc;
        eff_addr_i     = stim[i].addr;
        pf_ready_and_i = stim[i].rdy;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_i = 1'b1; v_i = 1'b0; pf_ready_and_i = 1'b0; pc_i = '0; eff_addr_i = '0;
        @(negedge clk);
        reset_i = 1'b0;
        stim.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; v_i = 1'b0; pf_ready_and_i = 1'b0; pc_i = '0; eff_addr_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pf_v_o !== 1'b0) begin failures++; $display("FAIL reset_pf_v got=%b exp=0", pf_v_o); end
        checks++;
        if (pf_addr_o !== '0) begin failures++; $display("FAIL reset_pf_addr got=%h exp=0", pf_addr_o); end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        reset_i = 1'b0;
    endtask

    task automatic test_basic();
        addr_t e;
        logic  ev;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0); add(1, PC_A, 'h180, 1, 0);
        idle(7, 1);
        exp_q.push_back('h1C0); exp_q.push_back('h200); exp_q.push_back('h240); exp_q.push_back('h280);
        foreach (stim[i]) begin
            drive(i);
            ev = (i >= 3 && i <= 6);
            checks++;
            if (pf_v_o !== ev) begin failures++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", i, pf_v_o, ev); end
            checks++;
            if (busy_o !== ev) begin failures++; $display("FAIL basic_busy cyc=%0d got=%b exp=%b", i, busy_o, ev); end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL basic_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL basic_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        addr_t e;
        logic  ev;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0); add(1, PC_A, 'h180, 1, 0);
        idle(3, 0); idle(6, 1);
        expect_burst('h180, 'h40, 4);
        foreach (stim[i]) begin
            drive(i);
            ev = (i >= 3 && i <= 9);
            checks++;
            if (pf_v_o !== ev) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, pf_v_o, ev); end
            if (i >= 3 && i <= 5) begin
                checks++;
                if (pf_addr_o !== addr_t'('h1C0)) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=1c0", i, pf_addr_o); end
            end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL bp_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL bp_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_steady_break();
        addr_t e;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0); add(1, PC_A, 'h180, 1, 0);
        idle(5, 1);
        add(1, PC_A, 'h1000, 1, 0);
        idle(3, 1);
        add(1, PC_A, 'h1040, 1, 0);
        idle(6, 1);
        expect_burst('h180, 'h40, 4);
        expect_burst('h1040, 'h40, 4);
        foreach (stim[i]) begin
            drive(i);
            if (i >= 9 && i <= 12) begin
                checks++;
                if (pf_v_o !== 1'b0) begin failures++; $display("FAIL break_noprefetch cyc=%0d got=%b exp=0", i, pf_v_o); end
            end
            if (i == 13) begin
                checks++;
                if (pf_v_o !== 1'b1) begin failures++; $display("FAIL break_relock cyc=%0d got=%b exp=1", i, pf_v_o); end
            end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL break_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL break_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL break_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_nonrepr();
        addr_t e;
        logic  ev;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0);   add(1, PC_A, 'h10140, 1, 0); add(1, PC_A, 'h20180, 1, 0);
        add(1, PC_A, 'h201C0, 1, 0); add(1, PC_A, 'h20200, 1, 0); add(1, PC_A, 'h20240, 1, 0);
        idle(6, 1);
        expect_burst('h20240, 'h40, 4);
        foreach (stim[i]) begin
            drive(i);
            ev = (i >= 6 && i <= 9);
            checks++;
            if (pf_v_o !== ev) begin failures++; $display("FAIL nonrepr_valid cyc=%0d got=%b exp=%b", i, pf_v_o, ev); end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL nonrepr_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL nonrepr_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL nonrepr_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_alias();
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_C, 'h500, 1, 0);
        add(1, PC_A, 'h140, 1, 0); add(1, PC_C, 'h540, 1, 0);
        add(1, PC_A, 'h180, 1, 0); add(1, PC_C, 'h580, 1, 0);
        add(1, PC_A, 'h1C0, 1, 0); add(1, PC_C, 'h5C0, 1, 0);
        idle(3, 1);
        foreach (stim[i]) begin
            drive(i);
            checks++;
            if (pf_v_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++; $display("FAIL alias_noprefetch cyc=%0d got=%b/%b exp=0/0", i, pf_v_o, busy_o);
            end
        end
    endtask

    task automatic test_preempt();
        addr_t e;
        logic  ev;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0);
        add(1, PC_B, 'h800, 1, 0); add(1, PC_B, 'h810, 1, 0);
        add(1, PC_A, 'h180, 1, 0); add(1, PC_B, 'h820, 1, 0);
        idle(5, 1);
        exp_q.push_back('h1C0);
        expect_burst('h820, 'h10, 4);
        foreach (stim[i]) begin
            drive(i);
            ev = (i >= 5 && i <= 9);
            checks++;
            if (pf_v_o !== ev) begin failures++; $display("FAIL preempt_valid cyc=%0d got=%b exp=%b", i, pf_v_o, ev); end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL preempt_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL preempt_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL preempt_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        addr_t e;
        logic  ev;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0); add(1, PC_A, 'h180, 1, 0);
        add(1, PC_B, 'h800, 1, 0); add(1, PC_B, 'h810, 1, 0);
        idle(1, 1);
        add(1, PC_B, 'h820, 1, 0);
        idle(5, 1);
        expect_burst('h180, 'h40, 4);
        expect_burst('h820, 'h10, 4);
        foreach (stim[i]) begin
            drive(i);
            ev = (i >= 3 && i <= 10);
            checks++;
            if (pf_v_o !== ev) begin failures++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, pf_v_o, ev); end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL b2b_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midburst();
        addr_t e;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0); add(1, PC_A, 'h180, 1, 0);
        idle(1, 1);
        add(1, PC_A, 'h200, 0, 1);
        idle(1, 0);
        add(1, PC_A, 'h240, 1, 0); add(1, PC_A, 'h280, 1, 0);
        idle(4, 1);
        exp_q.push_back('h1C0);
        foreach (stim[i]) begin
            drive(i);
            if (i == 5) begin
                checks++;
                if (pf_v_o !== 1'b0 || busy_o !== 1'b0 || pf_addr_o !== '0) begin
                    failures++; $display("FAIL rstmid_abort got=%b/%b/%h exp=0/0/0", pf_v_o, busy_o, pf_addr_o);
                end
            end
            if (i >= 6) begin
                checks++;
                if (pf_v_o !== 1'b0) begin failures++; $display("FAIL rstmid_cleared cyc=%0d got=%b exp=0", i, pf_v_o); end
            end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL rstmid_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL rstmid_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    task automatic test_runahead();
        addr_t e;
        apply_reset();
        add(1, PC_A, 'h100, 1, 0); add(1, PC_A, 'h140, 1, 0); add(1, PC_A, 'h180, 1, 0);
        idle(5, 1);
        add(1, PC_A, 'h1C0, 1, 0);
        idle(7, 1);
        expect_burst('h180, 'h40, 4);
`ifdef BP_BE_STRIDE_PF_RUNAHEAD_EN
        exp_q.push_back('h2C0);
`else
        expect_burst('h1C0, 'h40, 4);
`endif
        foreach (stim[i]) begin
            drive(i);
            if (i == 9) begin
                checks++;
                if (pf_v_o !== 1'b1) begin failures++; $display("FAIL runahead_latency got=%b exp=1", pf_v_o); end
            end
            if (pf_v_o && pf_ready_and_i) begin
                checks++;
                if (exp_q.size() == 0) begin failures++; $display("FAIL runahead_extra got=%h exp=none", pf_addr_o); end
                else begin
                    e = exp_q.pop_front();
                    if (pf_addr_o !== e) begin failures++; $display("FAIL runahead_addr got=%h exp=%h", pf_addr_o, e); end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL runahead_missing got=%0d left exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_steady_break();
        test_nonrepr();
        test_alias();
        test_preempt();
        test_back_to_back();
        test_reset_midburst();
        test_runahead();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
